// File: rtl/mtr_incr_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mtr_incr_sched_if                                             |
// | Purpose  : Bundle of the meter-increment scheduler's request/readout     |
// |            signals. The MTR counters, interval timer and PI/CTL side     |
// |            act as the master; the scheduler is the slave.                |
// | Signals  : OVF[3:0]      1-cycle overflow pulses (TIME,PERF,EBOX,CACHE)  |
// |            VEC_IN        interval-done level                             |
// |            HONOR         PI honor pulse                                  |
// |            READ_DONE     microcode readout-complete pulse                |
// |            FLUSH         CONO MTR clear                                  |
// |            INTERRUPT_REQ request to PI                                   |
// |            VECTOR_REQ    winner is the interval vector                   |
// |            INCR_SEL[1:0] winning counter index                           |
// |            HOLD_SEL      selection frozen for readout mux                |
// |            PENDING[3:0]  per-counter pending flags                       |
// |            OVERRUN[3:0]  sticky overflow-while-pending flags             |
// |            TIMEOUT_ERR   sticky HOLD timeout flag                        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface mtr_incr_sched_if;
  logic [3:0] OVF;
  logic       VEC_IN;
  logic       HONOR;
  logic       READ_DONE;
  logic       FLUSH;
  logic       INTERRUPT_REQ;
  logic       VECTOR_REQ;
  logic [1:0] INCR_SEL;
  logic       HOLD_SEL;
  logic [3:0] PENDING;
  logic [3:0] OVERRUN;
  logic       TIMEOUT_ERR;

  modport master (
    output OVF, VEC_IN, HONOR, READ_DONE, FLUSH,
    input  INTERRUPT_REQ, VECTOR_REQ, INCR_SEL, HOLD_SEL, PENDING, OVERRUN, TIMEOUT_ERR
  );

  modport slave (
    input  OVF, VEC_IN, HONOR, READ_DONE, FLUSH,
    output INTERRUPT_REQ, VECTOR_REQ, INCR_SEL, HOLD_SEL, PENDING, OVERRUN, TIMEOUT_ERR
  );
endinterface
`default_nettype wire

// File: rtl/mtr_incr_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mtr_incr_sched                                                |
// | Purpose  : Shares the meter board's single PI interrupt/readout path     |
// |            among the four meter counters and the interval-timer vector.  |
// |            Latches overflow pulses as pending requests, picks a winner,  |
// |            raises INTERRUPT_REQ, and freezes the selection from PI honor |
// |            through microcode readout.                                    |
// | Ports    : MBOX_CLK  clock, rising edge                                  |
// |            RESET     asynchronous, active-high                           |
// |            bus       mtr_incr_sched_if.slave (requests in, status out)   |
// | Params   : ACK_TIMEOUT  HOLD cycles allowed without READ_DONE (0 = off)  |
// |            TMO_W        timeout counter width, 2**TMO_W > ACK_TIMEOUT    |
// | Options  : MTR_RR_ARB_EN  round-robin among the four counters; when      |
// |                           undefined, fixed priority TIME>PERF>EBOX>CACHE |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mtr_incr_sched #(
  parameter int ACK_TIMEOUT = 255,
  parameter int TMO_W       = 8
) (
  input  wire logic        MBOX_CLK,
  input  wire logic        RESET,
  mtr_incr_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  logic [TMO_W-1:0] tmo_cnt;
  logic [3:0]       pending;
  logic [3:0]       overrun;
  logic             intr_req;
  logic             vec_req;
  logic [1:0]       incr_sel;
  logic             hold_sel;
  logic             tmo_err;

  logic [3:0]       read_clr;
  logic [3:0]       pending_nxt;
  logic [3:0]       overrun_nxt;
  logic             cand_any;
  logic             win_vec;
  logic [1:0]       win_idx;
  logic             tmo_hit;

  assign bus.INTERRUPT_REQ = intr_req;
  assign bus.VECTOR_REQ    = vec_req;
  assign bus.INCR_SEL      = incr_sel;
  assign bus.HOLD_SEL      = hold_sel;
  assign bus.PENDING       = pending;
  assign bus.OVERRUN       = overrun;
  assign bus.TIMEOUT_ERR   = tmo_err;

  // Readout completion only retires a counter; the vector source is
  // cleared externally by CONO TIM.
  always_comb begin
    read_clr = 4'b0000;
    if (state == HOLD && bus.READ_DONE && !vec_req)
      read_clr[incr_sel] = 1'b1;
  end

  // A new overflow wins over a same-cycle clear (readout or flush).
  assign pending_nxt = bus.OVF | (pending & ~read_clr & ~{4{bus.FLUSH}});

  // Overrun only counts when the earlier request is still going to be pending.
  assign overrun_nxt = bus.FLUSH ? 4'b0000 : (overrun | (bus.OVF & pending & ~read_clr));

  // Arbitrating on the next-cycle pending set gives one cycle from OVF to
  // INTERRUPT_REQ and lets a flush empty the candidate set on the same edge.
  assign cand_any = bus.VEC_IN | (|pending_nxt);

`ifdef MTR_RR_ARB_EN
  logic [1:0] rr_ptr;
  logic [1:0] rr_idx;

  // Scan from the farthest offset down so the entry closest to the pointer
  // is the last one written and therefore wins.
  always_comb begin
    win_vec = bus.VEC_IN;
    win_idx = 2'd0;
    rr_idx  = 2'd0;
    if (!bus.VEC_IN) begin
      for (int k = 3; k >= 0; k--) begin
        rr_idx = rr_ptr + 2'(k);
        if (pending_nxt[rr_idx])
          win_idx = rr_idx;
      end
    end
  end
`else
  always_comb begin
    win_vec = bus.VEC_IN;
    win_idx = 2'd0;
    if (!bus.VEC_IN) begin
      if      (pending_nxt[0]) win_idx = 2'd0;
      else if (pending_nxt[1]) win_idx = 2'd1;
      else if (pending_nxt[2]) win_idx = 2'd2;
      else if (pending_nxt[3]) win_idx = 2'd3;
      else                     win_idx = 2'd0;
    end
  end
`endif

  // The counter starts at 0 on HOLD entry, so matching ACK_TIMEOUT-1 ends
  // HOLD after exactly ACK_TIMEOUT cycles.
  assign tmo_hit = (ACK_TIMEOUT != 0) && (tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));

  always_ff @(posedge MBOX_CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      tmo_cnt  <= '0;
      pending  <= 4'b0000;
      overrun  <= 4'b0000;
      intr_req <= 1'b0;
      vec_req  <= 1'b0;
      incr_sel <= 2'd0;
      hold_sel <= 1'b0;
      tmo_err  <= 1'b0;
`ifdef MTR_RR_ARB_EN
      rr_ptr   <= 2'd0;
`endif
    end else begin
      pending <= pending_nxt;
      overrun <= overrun_nxt;
      case (state)
        IDLE: begin
          if (cand_any) begin
            state    <= REQ;
            intr_req <= 1'b1;
            vec_req  <= win_vec;
            incr_sel <= win_idx;
          end
        end
        REQ: begin
          if (!cand_any) begin
            state    <= IDLE;
            intr_req <= 1'b0;
            vec_req  <= 1'b0;
            incr_sel <= 2'd0;
          end else if (bus.HONOR) begin
            // Freeze what PI actually honored, not a fresh arbitration.
            state    <= HOLD;
            intr_req <= 1'b0;
            hold_sel <= 1'b1;
            tmo_cnt  <= '0;
`ifdef MTR_RR_ARB_EN
            if (!vec_req)
              rr_ptr <= incr_sel + 2'd1;
`endif
          end else begin
            vec_req  <= win_vec;
            incr_sel <= win_idx;
          end
        end
        HOLD: begin
          if (bus.FLUSH || bus.READ_DONE || tmo_hit) begin
            state    <= DONE;
            hold_sel <= 1'b0;
            vec_req  <= 1'b0;
            incr_sel <= 2'd0;
            tmo_cnt  <= '0;
            if (!bus.FLUSH && !bus.READ_DONE)
              tmo_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mtr_incr_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mtr_incr_sched                                             |
// | Purpose  : Self-checking bench for mtr_incr_sched: directed scenarios    |
// |            plus randomized traffic compared against a transaction-level  |
// |            reference model.                                              |
// | Options  : MTR_RR_ARB_EN selects the round-robin expectations.           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mtr_incr_sched;
  localparam int TMO = 4;

  logic mbox_clk;
  logic reset;
  int   total;
  int   passed;

  mtr_incr_sched_if bus();

  mtr_incr_sched #(.ACK_TIMEOUT(TMO), .TMO_W(8)) dut (
    .MBOX_CLK (mbox_clk),
    .RESET    (reset),
    .bus      (bus.slave)
  );

  initial mbox_clk = 1'b0;
  always #5 mbox_clk = ~mbox_clk;

  // Reference model: who is requesting, who is held, and what is pending.
  bit       m_req, m_held, m_dead, m_vecreq, m_err;
  int       m_sel, m_hold_cycles, m_ptr;
  bit [3:0] m_pend, m_ovr;

  task automatic model_clear();
    m_req = 0; m_held = 0; m_dead = 0; m_vecreq = 0; m_err = 0;
    m_sel = 0; m_hold_cycles = 0; m_ptr = 0; m_pend = 0; m_ovr = 0;
  endtask

  task automatic model_step();
    bit [3:0] clr, npend, novr;
    bit       any, wvec, found;
    int       wsel, idx;
    clr = 0;
    if (m_held && bus.READ_DONE && !m_vecreq) clr[m_sel] = 1;
    for (int i = 0; i < 4; i++) begin
      npend[i] = bus.OVF[i] || (m_pend[i] && !clr[i] && !bus.FLUSH);
      novr[i]  = !bus.FLUSH && (m_ovr[i] || (bus.OVF[i] && m_pend[i] && !clr[i]));
    end
    any = bus.VEC_IN || (npend != 0);
    wvec = bus.VEC_IN; wsel = 0; found = 0;
    if (!wvec) begin
      for (int k = 0; k < 4; k++) begin
        idx = (m_ptr + k) % 4;
        if (!found && npend[idx]) begin wsel = idx; found = 1; end
      end
    end
    if (m_dead) begin
      m_dead = 0;
    end else if (m_held) begin
      if (bus.FLUSH || bus.READ_DONE || (m_hold_cycles + 1 == TMO)) begin
        if (!bus.FLUSH && !bus.READ_DONE) m_err = 1;
        m_held = 0; m_dead = 1; m_vecreq = 0; m_sel = 0; m_hold_cycles = 0;
      end else begin
        m_hold_cycles++;
      end
    end else if (m_req) begin
      if (!any) begin
        m_req = 0; m_vecreq = 0; m_sel = 0;
      end else if (bus.HONOR) begin
        m_req = 0; m_held = 1; m_hold_cycles = 0;
`ifdef MTR_RR_ARB_EN
        if (!m_vecreq) m_ptr = (m_sel + 1) % 4;
`endif
      end else begin
        m_vecreq = wvec; m_sel = wsel;
      end
    end else if (any) begin
      m_req = 1; m_vecreq = wvec; m_sel = wsel;
    end
    m_pend = npend;
    m_ovr  = novr;
  endtask

  // One clock: advance the model with the applied inputs, let the edge pass,
  // then drop the single-cycle pulses.
  task automatic tick();
    model_step();
    @(posedge mbox_clk);
    #1;
    bus.OVF = 4'b0000; bus.HONOR = 1'b0; bus.READ_DONE = 1'b0; bus.FLUSH = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.OVF = 4'b0000; bus.VEC_IN = 1'b0; bus.HONOR = 1'b0;
    bus.READ_DONE = 1'b0; bus.FLUSH = 1'b0;
    model_clear();
    repeat (2) @(posedge mbox_clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({bus.INTERRUPT_REQ, bus.VECTOR_REQ, bus.INCR_SEL, bus.HOLD_SEL} !== 5'b0)
      $display("FAIL reset_req: got %b want 00000",
               {bus.INTERRUPT_REQ, bus.VECTOR_REQ, bus.INCR_SEL, bus.HOLD_SEL});
    else passed++;
    total++;
    if ({bus.PENDING, bus.OVERRUN, bus.TIMEOUT_ERR} !== 9'b0)
      $display("FAIL reset_flags: got %b want 000000000",
               {bus.PENDING, bus.OVERRUN, bus.TIMEOUT_ERR});
    else passed++;
  endtask

  task automatic test_single();
    do_reset();
    bus.OVF = 4'b0100; tick();
    total++;
    if ({bus.INTERRUPT_REQ, bus.VECTOR_REQ, bus.INCR_SEL} !== 4'b1010)
      $display("FAIL single_req: got %b want 1010",
               {bus.INTERRUPT_REQ, bus.VECTOR_REQ, bus.INCR_SEL});
    else passed++;
    bus.HONOR = 1'b1; tick();
    total++;
    if ({bus.HOLD_SEL, bus.INTERRUPT_REQ, bus.INCR_SEL} !== 4'b1010)
      $display("FAIL single_hold: got %b want 1010",
               {bus.HOLD_SEL, bus.INTERRUPT_REQ, bus.INCR_SEL});
    else passed++;
    bus.READ_DONE = 1'b1; tick();
    total++;
    if ({bus.PENDING, bus.HOLD_SEL, bus.INTERRUPT_REQ} !== 6'b000000)
      $display("FAIL single_done: got %b want 000000",
               {bus.PENDING, bus.HOLD_SEL, bus.INTERRUPT_REQ});
    else passed++;
    tick(); tick();
    total++;
    if ({bus.INTERRUPT_REQ, bus.HOLD_SEL, bus.INCR_SEL} !== 4'b0000)
      $display("FAIL single_idle: got %b want 0000",
               {bus.INTERRUPT_REQ, bus.HOLD_SEL, bus.INCR_SEL});
    else passed++;
  endtask

  task automatic test_preempt();
    do_reset();
    bus.OVF = 4'b1000; tick();
    total++;
    if (bus.INCR_SEL !== 2'd3) $display("FAIL preempt_cache: got %0d want 3", bus.INCR_SEL);
    else passed++;
    bus.VEC_IN = 1'b1; tick();
    total++;
    if ({bus.INTERRUPT_REQ, bus.VECTOR_REQ, bus.INCR_SEL} !== 4'b1100)
      $display("FAIL preempt_vec: got %b want 1100",
               {bus.INTERRUPT_REQ, bus.VECTOR_REQ, bus.INCR_SEL});
    else passed++;
    bus.HONOR = 1'b1; tick();
    bus.READ_DONE = 1'b1; tick();
    total++;
    if (bus.PENDING !== 4'b1000) $display("FAIL preempt_keep: got %b want 1000", bus.PENDING);
    else passed++;
    bus.VEC_IN = 1'b0; tick(); tick();
    total++;
    if ({bus.INTERRUPT_REQ, bus.VECTOR_REQ, bus.INCR_SEL} !== 4'b1011)
      $display("FAIL preempt_rereq: got %b want 1011",
               {bus.INTERRUPT_REQ, bus.VECTOR_REQ, bus.INCR_SEL});
    else passed++;
  endtask

  task automatic test_overrun();
    do_reset();
    bus.OVF = 4'b0010; tick();
    bus.OVF = 4'b0010; tick();
    total++;
    if (bus.OVERRUN !== 4'b0010) $display("FAIL overrun_set: got %b want 0010", bus.OVERRUN);
    else passed++;
    bus.HONOR = 1'b1; tick();
    bus.READ_DONE = 1'b1; bus.OVF = 4'b0010; tick();
    total++;
    if ({bus.PENDING, bus.OVERRUN} !== 8'b0010_0010)
      $display("FAIL overrun_collide: got %b want 00100010", {bus.PENDING, bus.OVERRUN});
    else passed++;
  endtask

  task automatic test_timeout();
    do_reset();
    bus.OVF = 4'b0001; tick();
    bus.HONOR = 1'b1; tick();
    repeat (TMO - 1) tick();
    total++;
    if ({bus.HOLD_SEL, bus.TIMEOUT_ERR} !== 2'b10)
      $display("FAIL timeout_early: got %b want 10", {bus.HOLD_SEL, bus.TIMEOUT_ERR});
    else passed++;
    tick();
    total++;
    if ({bus.HOLD_SEL, bus.TIMEOUT_ERR, bus.PENDING} !== 6'b01_0001)
      $display("FAIL timeout_hit: got %b want 010001",
               {bus.HOLD_SEL, bus.TIMEOUT_ERR, bus.PENDING});
    else passed++;
    tick(); tick();
    total++;
    if ({bus.INTERRUPT_REQ, bus.INCR_SEL} !== 3'b100)
      $display("FAIL timeout_rereq: got %b want 100", {bus.INTERRUPT_REQ, bus.INCR_SEL});
    else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    bus.OVF = 4'b1111; tick();
    bus.OVF = 4'b1111; tick();
    bus.FLUSH = 1'b1; tick();
    total++;
    if ({bus.INTERRUPT_REQ, bus.INCR_SEL, bus.PENDING, bus.OVERRUN} !== 11'b0)
      $display("FAIL flush_req: got %b want 00000000000",
               {bus.INTERRUPT_REQ, bus.INCR_SEL, bus.PENDING, bus.OVERRUN});
    else passed++;
  endtask

  task automatic test_reset_hold();
    do_reset();
    bus.OVF = 4'b0100; tick();
    bus.HONOR = 1'b1; tick();
    reset = 1'b1;
    #2;
    total++;
    if ({bus.HOLD_SEL, bus.INCR_SEL, bus.PENDING} !== 7'b0)
      $display("FAIL reset_async: got %b want 0000000",
               {bus.HOLD_SEL, bus.INCR_SEL, bus.PENDING});
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_rounds();
    int want;
    do_reset();
    bus.OVF = 4'b1111; tick();
    for (int r = 0; r < 4; r++) begin
`ifdef MTR_RR_ARB_EN
      want = r;
`else
      want = 0;
`endif
      total++;
      if ({bus.INTERRUPT_REQ, bus.INCR_SEL} !== {1'b1, 2'(want)})
        $display("FAIL round_sel[%0d]: got req=%b sel=%0d want req=1 sel=%0d",
                 r, bus.INTERRUPT_REQ, bus.INCR_SEL, want);
      else passed++;
      bus.HONOR = 1'b1; tick();
      bus.READ_DONE = 1'b1;
`ifndef MTR_RR_ARB_EN
      bus.OVF = 4'b0001;
`endif
      tick(); tick(); tick();
    end
  endtask

  task automatic test_random();
    logic [14:0] got, exp;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) bus.OVF[i] = ($urandom_range(7) == 0);
      bus.HONOR     = ($urandom_range(2) == 0);
      bus.READ_DONE = ($urandom_range(2) == 0);
      bus.FLUSH     = ($urandom_range(40) == 0);
      if ($urandom_range(25) == 0) bus.VEC_IN = ~bus.VEC_IN;
      tick();
      got = {bus.INTERRUPT_REQ, bus.VECTOR_REQ, bus.INCR_SEL, bus.HOLD_SEL,
             bus.PENDING, bus.OVERRUN, bus.TIMEOUT_ERR};
      exp = {m_req, m_vecreq, 2'(m_sel), m_held, m_pend, m_ovr, m_err};
      total++;
      if (got !== exp)
        $display("FAIL random[%0d]: got %b want %b (req,vec,sel,hold,pend,ovr,err)",
                 c, got, exp);
      else passed++;
    end
  endtask

  initial begin
    total = 0;
    passed = 0;
    reset = 1'b1;
    test_reset();
    test_single();
    test_preempt();
    test_overrun();
    test_timeout();
    test_flush();
    test_reset_hold();
    test_rounds();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
